// File: rtl/elevator_pkg.sv
// Shared types for the car-position path: floor code width, floor type and FSM states.
package elevator_pkg;

  localparam int FLOOR_W = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/floor_position_tracker_travel_timer.sv
// Per-floor travel timer: loadable down-counter that parks at zero and flags it.
module travel_timer #(
  parameter int TRAVEL_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int CW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TRAVEL_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/floor_position_tracker.sv
// Car-position tracker: accepts a target floor and steps the car one floor per TRAVEL_CYCLES.
// Optional emergency stop (estop input, HALT state) is built when STOP_EN is defined.
module floor_position_tracker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   req_valid,
  input  floor_t req_floor,
`ifdef STOP_EN
  input  logic   estop,
`endif
  output logic   req_ready,
  output floor_t floor,
  output logic   moving,
  output logic   dir_up,
  output logic   arrived,
  output logic   error
);

  localparam logic [31:0] NUM_FLOORS_U = 32'(NUM_FLOORS);

  state_t r_state;
  floor_t r_floor;
  floor_t r_target;
  logic   r_moving;
  logic   r_dir;
  logic   r_arrived;
  logic   r_error;

  logic   w_estop;
  logic   w_inRange;
  logic   w_sameFloor;
  logic   w_travel;
  logic   w_zero;
  logic   w_step;
  logic   w_startTrip;
  floor_t w_nextFloor;

`ifdef STOP_EN
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  assign w_inRange   = ({{(32-FLOOR_W){1'b0}}, req_floor} < NUM_FLOORS_U);
  assign w_sameFloor = (req_floor == r_floor);
  assign w_startTrip = (r_state == IDLE) && req_valid && w_inRange && !w_sameFloor;

  // A released HALT counts as a travel cycle so a stop delays the step by exactly its length.
  assign w_travel    = ((r_state == MOVE) || (r_state == HALT)) && !w_estop;
  assign w_step      = w_travel && w_zero;
  assign w_nextFloor = r_dir ? (r_floor + floor_t'(1)) : (r_floor - floor_t'(1));

  travel_timer #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_load(w_startTrip || w_step),
    .i_en  (w_travel),
    .o_zero(w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_floor   <= '0;
      r_target  <= '0;
      r_moving  <= 1'b0;
      r_dir     <= 1'b0;
      r_arrived <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      r_error   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (!w_inRange) begin
              r_error <= 1'b1;
            end else if (w_sameFloor) begin
              r_state   <= ARRIVE;
              r_arrived <= 1'b1;
            end else begin
              r_target <= req_floor;
              r_dir    <= (req_floor > r_floor);
              r_moving <= 1'b1;
              r_state  <= MOVE;
            end
          end
        end
        MOVE, HALT: begin
          if (w_estop) begin
            r_state  <= HALT;
            r_moving <= 1'b0;
          end else begin
            r_state  <= MOVE;
            r_moving <= 1'b1;
            if (w_zero) begin
              r_floor <= w_nextFloor;
              if (w_nextFloor == r_target) begin
                r_state   <= ARRIVE;
                r_moving  <= 1'b0;
                r_arrived <= 1'b1;
              end
            end
          end
        end
        ARRIVE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign floor     = r_floor;
  assign moving    = r_moving;
  assign dir_up    = r_dir;
  assign arrived   = r_arrived;
  assign error     = r_error;

endmodule

// File: tb/tb_floor_position_tracker.sv
// Self-checking bench for floor_position_tracker: vector table, corner sequences and a random
// run compared each cycle against a trip-timing reference model (estop sequence under STOP_EN).
module tb_floor_position_tracker;
  import elevator_pkg::*;

  localparam int NF = 5;
  localparam int TC = 8;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   req_valid = 1'b0;
  floor_t req_floor = '0;
`ifdef STOP_EN
  logic   estop = 1'b0;
`endif
  logic   req_ready;
  floor_t floor;
  logic   moving;
  logic   dir_up;
  logic   arrived;
  logic   error;

  floor_position_tracker #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_floor(req_floor),
`ifdef STOP_EN
    .estop    (estop),
`endif
    .req_ready(req_ready),
    .floor    (floor),
    .moving   (moving),
    .dir_up   (dir_up),
    .arrived  (arrived),
    .error    (error)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a trip is described by its start edge, start floor and target; the car
  // position follows from elapsed edges divided by the per-floor travel time.
  bit mIdle, mTravel, mArrive, mMoving, mDir, mArr, mErr;
  int mCyc, mE0, mStart, mTarget, mFloor, mSteps, mDist;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mIdle = 1; mTravel = 0; mArrive = 0; mMoving = 0; mDir = 0; mArr = 0; mErr = 0;
      mCyc = 0; mE0 = 0; mStart = 0; mTarget = 0; mFloor = 0;
    end else begin
      mCyc++;
      mArr = 0;
      mErr = 0;
      if (mArrive) begin
        mArrive = 0;
        mIdle   = 1;
      end else if (mTravel) begin
        mSteps = (mCyc - mE0) / TC;
        mDist  = mDir ? (mTarget - mStart) : (mStart - mTarget);
        mFloor = mDir ? (mStart + mSteps) : (mStart - mSteps);
        if (mSteps == mDist) begin
          mTravel = 0; mArrive = 1; mMoving = 0; mArr = 1;
        end
      end else if (mIdle && req_valid) begin
        if (int'(req_floor) >= NF) begin
          mErr = 1;
        end else if (int'(req_floor) == mFloor) begin
          mIdle = 0; mArrive = 1; mArr = 1;
        end else begin
          mIdle = 0; mTravel = 1; mE0 = mCyc; mStart = mFloor; mTarget = int'(req_floor);
          mDir = (mTarget > mStart); mMoving = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("model.floor", 32'(floor), 32'(mFloor));
      checkOutput("model.moving", 32'(moving), 32'(mMoving));
      checkOutput("model.dir_up", 32'(dir_up), 32'(mDir));
      checkOutput("model.arrived", 32'(arrived), 32'(mArr));
      checkOutput("model.error", 32'(error), 32'(mErr));
      checkOutput("model.req_ready", 32'(req_ready), 32'(mIdle));
    end
  end

  // One-cycle request; lat counts edges after the handshake edge until arrived/error shows.
  task automatic applyStimulus(input int f, output int lat, output bit sawErr, output bit sawArr);
    @(negedge clk);
    req_valid = 1'b1;
    req_floor = floor_t'(f);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (lat < 200 && !arrived && !error) begin
      @(negedge clk);
      lat++;
    end
    sawErr = error;
    sawArr = arrived;
  endtask

  typedef struct {
    int reqFloor;
    bit expErr;
    int expLat;
    int expFloor;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, n;
    bit sawErr, sawArr;

    vecs[0] = '{3,  1'b0, 3*TC, 3};
    vecs[1] = '{1,  1'b0, 2*TC, 1};
    vecs[2] = '{7,  1'b1, 0,    1};
    vecs[3] = '{0,  1'b0, 1*TC, 0};
    vecs[4] = '{4,  1'b0, 4*TC, 4};
    vecs[5] = '{4,  1'b0, 0,    4};
    vecs[6] = '{15, 1'b1, 0,    4};
    vecs[7] = '{2,  1'b0, 2*TC, 2};
    vecs[8] = '{0,  1'b0, 2*TC, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset.floor", 32'(floor), 0);
    checkOutput("reset.req_ready", 32'(req_ready), 1);
    checkOutput("reset.moving", 32'(moving), 0);
    checkOutput("reset.arrived", 32'(arrived), 0);
    checkOutput("reset.error", 32'(error), 0);
    checkEn = 1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].reqFloor, lat, sawErr, sawArr);
      checkOutput($sformatf("vec%0d.error", i), 32'(sawErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.arrived", i), 32'(sawArr), 32'(!vecs[i].expErr));
      checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d.floor", i), 32'(floor), 32'(vecs[i].expFloor));
      @(negedge clk);
      checkOutput($sformatf("vec%0d.ready_after", i), 32'(req_ready), 1);
    end

    // Requests held during travel must not redirect the car.
    @(negedge clk);
    req_valid = 1'b1;
    req_floor = floor_t'(3);
    @(negedge clk);
    req_floor = floor_t'(1);
    lat = 0;
    while (lat < 200 && !arrived) begin
      if (lat == 10) req_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    checkOutput("ignore.latency", 32'(lat), 32'(3*TC));
    checkOutput("ignore.floor", 32'(floor), 3);

    // Asynchronous reset while travelling down through floor 2.
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_floor = floor_t'(0);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (n < 100 && floor != floor_t'(2)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midreset.reached_floor2", 32'(floor), 2);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset.floor", 32'(floor), 0);
    checkOutput("midreset.req_ready", 32'(req_ready), 1);
    checkOutput("midreset.moving", 32'(moving), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) == 0);
      req_floor = floor_t'($urandom_range(0, 7));
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (n < 200 && !req_ready) begin
      @(negedge clk);
      n++;
    end
    checkOutput("random.drain_ready", 32'(req_ready), 1);

`ifdef STOP_EN
    // Emergency stop held for 5 edges mid-floor delays the step by exactly 5 cycles.
    checkEn = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_floor = floor_t'(1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (lat < 200 && !arrived) begin
      if (lat == 3) estop = 1'b1;
      if (lat == 8) estop = 1'b0;
      if (lat == 5) begin
        checkOutput("estop.moving_halted", 32'(moving), 0);
        checkOutput("estop.ready_halted", 32'(req_ready), 0);
      end
      @(negedge clk);
      lat++;
    end
    estop = 1'b0;
    checkOutput("estop.latency", 32'(lat), 32'(TC + 5));
    checkOutput("estop.floor", 32'(floor), 1);
`endif

    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
